// File: rtl/int_to_float.sv
// Iterative signed-integer to IEEE-754 single-precision converter.
// Normalises the magnitude one bit per clock, then rounds to nearest-even.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   inTrigger  start pulse; inData sampled on the same edge (restarts any work)
//   inData     signed two's-complement operand, IN_WIDTH bits
//   outReady   1 = idle and outData valid, 0 = conversion in progress
//   outData    {sign, exp[7:0], mant[22:0]}, held until the next result
module int_to_float #(
   parameter int unsigned IN_WIDTH = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                inTrigger,
   input  logic [IN_WIDTH-1:0] inData,
   output logic                outReady,
   output logic [31:0]         outData
);

   localparam int unsigned MANT_W   = 23;
   localparam int unsigned EXP_W    = 8;
   localparam int unsigned MSB      = IN_WIDTH - 1;
   localparam int unsigned EXP_INIT = 127 + IN_WIDTH - 1;

   typedef enum logic [1:0] {
      IDLE,
      NORM,
      ROUND
   } state_t;

   state_t              state, stateNext;
   logic [IN_WIDTH-1:0] mag, magNext;
   logic [EXP_W-1:0]    exp, expNext;
   logic                sign, signNext;
   logic                readyNext;
   logic [31:0]         dataNext;

   logic [MANT_W-1:0]   mant;
   logic                guard;
   logic                sticky;
   logic                inc;
   logic [MANT_W:0]     mantSum;

   // Rounding fields taken from the normalised magnitude (MSB is the hidden one)
   always_comb begin
      mant    = mag[MSB-1 -: MANT_W];
      guard   = mag[MSB-MANT_W-1];
      sticky  = |mag[MSB-MANT_W-2:0];
      inc     = guard & (sticky | mant[0]);
      mantSum = {1'b0, mant} + (MANT_W+1)'(inc);
   end

   // State register and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         mag      <= '0;
         exp      <= '0;
         sign     <= 1'b0;
         outReady <= 1'b1;
         outData  <= '0;
      end else begin
         state    <= stateNext;
         mag      <= magNext;
         exp      <= expNext;
         sign     <= signNext;
         outReady <= readyNext;
         outData  <= dataNext;
      end
   end

   // Next-state and next-output logic; a trigger overrides whatever is in flight
   always_comb begin
      stateNext = state;
      magNext   = mag;
      expNext   = exp;
      signNext  = sign;
      readyNext = outReady;
      dataNext  = outData;

      if (inTrigger) begin
         signNext = inData[MSB];
         // Most-negative input negates to itself, which is the correct unsigned magnitude
         magNext  = inData[MSB] ? (~inData + IN_WIDTH'(1)) : inData;
         expNext  = EXP_W'(EXP_INIT);
         if (inData == '0) begin
            dataNext  = '0;
            readyNext = 1'b1;
            stateNext = IDLE;
         end else begin
            readyNext = 1'b0;
            stateNext = NORM;
         end
      end else begin
         case (state)
            IDLE: begin
               readyNext = 1'b1;
            end
            NORM: begin
               if (mag[MSB]) begin
                  stateNext = ROUND;
               end else begin
                  magNext = mag << 1;
                  expNext = exp - EXP_W'(1);
               end
            end
            ROUND: begin
               // A mantissa carry leaves the low bits zero and bumps the exponent
               dataNext  = {sign, exp + EXP_W'(mantSum[MANT_W]), mantSum[MANT_W-1:0]};
               readyNext = 1'b1;
               stateNext = IDLE;
            end
            default: begin
               stateNext = IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_int_to_float.sv
module tb_int_to_float;

   logic        clk;
   logic        rst;
   logic        inTrigger;
   logic [63:0] inData;
   logic        outReady;
   logic [31:0] outData;

   int testsRun;
   int testsFailed;

   int_to_float #(.IN_WIDTH(64)) dut (
      .clk       (clk),
      .rst       (rst),
      .inTrigger (inTrigger),
      .inData    (inData),
      .outReady  (outReady),
      .outData   (outData)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: IEEE single encoding of a 64-bit signed integer, round-to-nearest-even
   function automatic logic [31:0] refFloat(input logic [63:0] x);
      logic        s;
      logic [63:0] m, q, r, half;
      int          p, sh;
      if (x == 64'd0) return 32'h0;
      s = x[63];
      m = s ? (64'd0 - x) : x;
      p = 0;
      for (int i = 0; i < 64; i++) if (m[i]) p = i;
      if (p <= 23) begin
         q = m << (23 - p);
      end else begin
         sh   = p - 23;
         q    = m >> sh;
         r    = m & ((64'd1 << sh) - 64'd1);
         half = 64'd1 << (sh - 1);
         if (r > half || (r == half && q[0])) q = q + 64'd1;
         if (q == (64'd1 << 24)) begin
            q = q >> 1;
            p = p + 1;
         end
      end
      return {s, 8'(127 + p), q[22:0]};
   endfunction

   function automatic int refLatency(input logic [63:0] x);
      logic [63:0] m;
      int p;
      m = x[63] ? (64'd0 - x) : x;
      p = 0;
      for (int i = 0; i < 64; i++) if (m[i]) p = i;
      return (63 - p) + 2;
   endfunction

   // Float-to-int stage model, exact for magnitudes below 2^24
   function automatic logic [63:0] floatToInt(input logic [31:0] f);
      logic [63:0] v;
      int e;
      if (f[30:0] == 31'd0) return 64'd0;
      e = int'(f[30:23]);
      v = {40'd0, 1'b1, f[22:0]};
      if (e >= 150) v = v << (e - 150);
      else          v = v >> (150 - e);
      return f[31] ? (64'd0 - v) : v;
   endfunction

   // Pulse trigger for one edge; returns edges from trigger until outReady (bounded)
   task automatic convert(input logic [63:0] x, output int lat);
      inData    = x;
      inTrigger = 1'b1;
      @(posedge clk); #1;
      inTrigger = 1'b0;
      lat = 0;
      while (!outReady && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; inTrigger = 1'b0; inData = '0;
      repeat (3) @(posedge clk);
      #1;
      testsRun++;
      if (outReady !== 1'b1 || outData !== 32'h0) begin
         $display("FAIL reset: outReady=%b outData=%h, required 1 / 00000000", outReady, outData);
         testsFailed++;
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_vectors();
      logic [63:0] vals [7];
      logic [31:0] exp  [7];
      int          lats [7];
      int lat;
      vals[0] = 64'd1;                  exp[0] = 32'h3F800000; lats[0] = 65;
      vals[1] = 64'hFFFFFFFFFFFFFFFF;   exp[1] = 32'hBF800000; lats[1] = 65;
      vals[2] = 64'd16777217;           exp[2] = 32'h4B800000; lats[2] = 41;
      vals[3] = 64'd16777219;           exp[3] = 32'h4B800002; lats[3] = 41;
      vals[4] = 64'h8000000000000000;   exp[4] = 32'hDF000000; lats[4] = 2;
      vals[5] = 64'h7FFFFFFFFFFFFFFF;   exp[5] = 32'h5F000000; lats[5] = 3;
      vals[6] = 64'd1000;               exp[6] = 32'h447A0000; lats[6] = 56;
      for (int i = 0; i < 7; i++) begin
         convert(vals[i], lat);
         testsRun++;
         if (outData !== exp[i]) begin
            $display("FAIL vector_data[%0d]: got %h, required %h", i, outData, exp[i]);
            testsFailed++;
         end
         testsRun++;
         if (lat !== lats[i]) begin
            $display("FAIL vector_latency[%0d]: got %0d, required %0d", i, lat, lats[i]);
            testsFailed++;
         end
      end
   endtask

   task automatic test_zero();
      int lat;
      int dropped;
      convert(64'd5, lat);
      inData = 64'd0;
      inTrigger = 1'b1;
      @(posedge clk); #1;
      inTrigger = 1'b0;
      testsRun++;
      if (outData !== 32'h0 || outReady !== 1'b1) begin
         $display("FAIL zero_input: outData=%h outReady=%b, required 00000000 / 1", outData, outReady);
         testsFailed++;
      end
      dropped = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (outReady !== 1'b1 || outData !== 32'h0) dropped++;
      end
      testsRun++;
      if (dropped != 0) begin
         $display("FAIL zero_hold: %0d unstable cycles, required 0", dropped);
         testsFailed++;
      end
   endtask

   task automatic test_retrigger();
      int lat;
      logic [31:0] prev;
      int changed;
      convert(64'd3, lat);
      prev = outData;
      inData = 64'd1;
      inTrigger = 1'b1;
      @(posedge clk); #1;
      inTrigger = 1'b0;
      changed = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (outData !== prev || outReady !== 1'b0) changed++;
      end
      testsRun++;
      if (changed != 0) begin
         $display("FAIL busy_hold: %0d cycles with changed output, required 0", changed);
         testsFailed++;
      end
      convert(64'd1000, lat);
      testsRun++;
      if (outData !== 32'h447A0000 || lat !== 56) begin
         $display("FAIL retrigger: got %h lat %0d, required 447a0000 lat 56", outData, lat);
         testsFailed++;
      end
   endtask

   task automatic test_reset_mid();
      inData = 64'd1;
      inTrigger = 1'b1;
      @(posedge clk); #1;
      inTrigger = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      testsRun++;
      if (outReady !== 1'b1 || outData !== 32'h0) begin
         $display("FAIL reset_mid: outReady=%b outData=%h, required 1 / 00000000", outReady, outData);
         testsFailed++;
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      logic [63:0] x;
      int lat, badData, badLat;
      badData = 0; badLat = 0;
      for (int i = 0; i < 800; i++) begin
         x = {$urandom, $urandom} >> $urandom_range(0, 63);
         if ($urandom_range(0, 1) == 1) x = 64'd0 - x;
         if (x == 64'd0) x = 64'd7;
         convert(x, lat);
         testsRun++;
         if (outData !== refFloat(x)) begin
            badData++;
            testsFailed++;
            if (badData <= 5)
               $display("FAIL random_data: x=%h got %h, required %h", x, outData, refFloat(x));
         end
         testsRun++;
         if (lat !== refLatency(x)) begin
            badLat++;
            testsFailed++;
            if (badLat <= 5)
               $display("FAIL random_latency: x=%h got %0d, required %0d", x, lat, refLatency(x));
         end
      end
   endtask

   task automatic test_round_trip();
      logic [63:0] x;
      int lat, bad;
      bad = 0;
      for (int i = 0; i < 200; i++) begin
         x = 64'($urandom_range(1, 24'hFFFFFF));
         if ($urandom_range(0, 1) == 1) x = 64'd0 - x;
         convert(x, lat);
         testsRun++;
         if (floatToInt(outData) !== x) begin
            bad++;
            testsFailed++;
            if (bad <= 5)
               $display("FAIL round_trip: x=%h float %h returns %h", x, outData, floatToInt(outData));
         end
      end
   endtask

   initial begin
      testsRun = 0;
      testsFailed = 0;
      rst = 1'b1;
      inTrigger = 1'b0;
      inData = '0;
      test_reset();
      test_vectors();
      test_zero();
      test_retrigger();
      test_reset_mid();
      test_random();
      test_round_trip();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
